// File: rtl/ttc_apb_pkg.sv
// Shared definitions for the TTC APB bridge: register map, bit positions,
// APB FSM state encoding and helpers.
package ttc_apb_pkg;

    localparam logic [12:0] OFF_CTRL  = 13'h000;
    localparam logic [12:0] OFF_SCID  = 13'h004;
    localparam logic [12:0] OFF_MASK  = 13'h008;
    localparam logic [12:0] OFF_ADDR  = 13'h00C;
    localparam logic [12:0] OFF_INTEN = 13'h010;
    localparam logic [12:0] OFF_INTST = 13'h014;
    localparam logic [12:0] OFF_TMLEN = 13'h018;
    localparam logic [12:0] OFF_TCLEN = 13'h01C;
    localparam logic [12:0] OFF_TMCNT = 13'h030;
    localparam logic [12:0] OFF_TCCNT = 13'h034;
    localparam logic [12:0] OFF_TCERR = 13'h038;

    localparam int TX_BIT       = 0;
    localparam int RX_BIT       = 16;
    localparam int STAT_RXING   = 30;
    localparam int STAT_SENDING = 31;

    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RESP
    } apb_state_t;

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/ttc_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports: i_clk, i_rst (async, active-high), i_async (foreign-domain level),
//        o_rise (one-cycle pulse on a synchronised 0->1 transition).
module ttc_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/ttc_apb_bridge_mc.sv
// APB3 slave between the MSS and N_TX telemetry / N_RX telecommand buffers.
// Ports: APB (PSEL..PSLVERR), status inputs (SpacecraftID, counters, flags),
//        Tx/Rx finish events in, Tx_Start/Rx_Ready/Irq/MASK/ADDR out,
//        TX RAM write port (TXM_*) and RX RAM read port (RXM_*).
module ttc_apb_bridge_mc
    import ttc_apb_pkg::*;
#(
    parameter int          N_TX      = 2,
    parameter int          N_RX      = 2,
    parameter int          BUF_AW    = 8,
    parameter int          RD_LAT    = 1,
    parameter int          SWAP_RD   = 1,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          TM_LEN    = 1784,
    parameter int          TC_LEN    = 1792
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           PSEL,
    input  logic                           PENABLE,
    input  logic                           PWRITE,
    input  logic [31:0]                    PADDR,
    input  logic [31:0]                    PWDATA,
    output logic [31:0]                    PRDATA,
    output logic                           PREADY,
    output logic                           PSLVERR,
    input  logic [15:0]                    SpacecraftID,
    input  logic [31:0]                    TM_Packet_Counter,
    input  logic [31:0]                    TC_Packet_Counter,
    input  logic [31:0]                    TC_Error_Counter,
    input  logic                           Flag_Sending,
    input  logic                           Flag_RX_ing,
    input  logic [N_TX-1:0]                Tx_Finish,
    input  logic [N_RX-1:0]                Rx_Finish,
    output logic [N_TX-1:0]                Tx_Start,
    output logic [N_RX-1:0]                Rx_Ready,
    output logic                           Irq,
    output logic [15:0]                    MASK,
    output logic [15:0]                    ADDR,
    output logic                           TXM_WEN,
    output logic [$clog2(N_TX)+BUF_AW-1:0] TXM_WA,
    output logic [31:0]                    TXM_WD,
    output logic                           RXM_REN,
    output logic [$clog2(N_RX)+BUF_AW-1:0] RXM_RA,
    input  logic [31:0]                    RXM_RD
);

    localparam int TXA_W = $clog2(N_TX) + BUF_AW;
    localparam int RXA_W = $clog2(N_RX) + BUF_AW;
    localparam logic [31:0] INT_MASK =
        ((32'd1 << N_TX) - 32'd1) |
        (((32'd1 << N_RX) - 32'd1) << RX_BIT);

    apb_state_t r_state, w_nstate;

    logic              r_pready, r_pslverr, r_irq;
    logic [31:0]       r_prdata, r_int_stat, r_int_en;
    logic [1:0]        r_cnt;
    logic [15:0]       r_mask, r_addr;
    logic [N_TX-1:0]   r_tx_start;
    logic [N_RX-1:0]   r_rx_ready;
    logic              r_txm_wen, r_rxm_ren;
    logic [TXA_W-1:0]  r_txm_wa;
    logic [RXA_W-1:0]  r_rxm_ra;
    logic [31:0]       r_txm_wd;

    logic        w_hit, w_reg, w_tx, w_rx, w_idx_ok, w_lock;
    logic        w_reg_err, w_err, w_rd_rx, w_acc, w_cap, w_wr_ok;
    logic        w_ctrl_wr, w_intst_wr;
    logic [31:0] w_rgn, w_txc, w_rxc, w_word;
    logic [31:0] w_reg_rd, w_status, w_rx_data;
    logic [31:0] w_int_set, w_int_clr;
    logic [12:0] w_off;
    logic [N_TX-1:0] w_txsel, w_tx_rise, w_tx_set, w_tx_done;
    logic [N_RX-1:0] w_rx_rise, w_rx_clr;
    logic        w_unused;

    // Decode
    assign w_hit    = PADDR[31:18] == BASE_ADDR[31:18];
    assign w_rgn    = 32'(PADDR[17:13]);
    assign w_word   = 32'(PADDR[12:2]);
    assign w_off    = {PADDR[12:2], 2'b00};
    assign w_reg    = w_rgn == 32'd0;
    assign w_tx     = w_rgn >= 32'd1 && w_rgn <= 32'(N_TX);
    assign w_rx     = w_rgn > 32'(N_TX) && w_rgn <= 32'(N_TX + N_RX);
    assign w_txc    = w_rgn - 32'd1;
    assign w_rxc    = w_rgn - 32'(N_TX) - 32'd1;
    assign w_idx_ok = (w_word >> BUF_AW) == 32'd0;
    assign w_txsel  = N_TX'(1) << w_txc;
    assign w_lock   = |(r_tx_start & w_txsel);
    assign w_unused = ^PADDR[1:0];

    always_comb begin
        w_status = '0;
        w_status[TX_BIT +: N_TX] = r_tx_start;
        w_status[RX_BIT +: N_RX] = r_rx_ready;
        w_status[STAT_RXING]     = Flag_RX_ing;
        w_status[STAT_SENDING]   = Flag_Sending;
    end

    always_comb begin
        w_reg_rd  = '0;
        w_reg_err = 1'b0;
        case (w_off)
            OFF_CTRL:  w_reg_rd = w_status;
            OFF_SCID:  begin w_reg_rd = 32'(SpacecraftID); w_reg_err = PWRITE; end
            OFF_MASK:  w_reg_rd = 32'(r_mask);
            OFF_ADDR:  w_reg_rd = 32'(r_addr);
            OFF_INTEN: w_reg_rd = r_int_en;
            OFF_INTST: w_reg_rd = r_int_stat;
            OFF_TMLEN: begin w_reg_rd = 32'(TM_LEN); w_reg_err = PWRITE; end
            OFF_TCLEN: begin w_reg_rd = 32'(TC_LEN); w_reg_err = PWRITE; end
            OFF_TMCNT: begin w_reg_rd = TM_Packet_Counter; w_reg_err = PWRITE; end
            OFF_TCCNT: begin w_reg_rd = TC_Packet_Counter; w_reg_err = PWRITE; end
            OFF_TCERR: begin w_reg_rd = TC_Error_Counter; w_reg_err = PWRITE; end
            default:   w_reg_err = 1'b1;
        endcase
    end

    // TX windows are write-only and RX windows read-only.
    assign w_err = w_reg ? w_reg_err :
                   w_tx  ? (!PWRITE || !w_idx_ok || w_lock) :
                   w_rx  ? (PWRITE || !w_idx_ok) : 1'b1;
    assign w_rd_rx = w_rx & ~PWRITE & ~w_err;

    // APB FSM
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) r_state <= ST_IDLE;
        else     r_state <= w_nstate;
    end

    always_comb begin
        w_nstate = r_state;
        w_acc    = 1'b0;
        w_cap    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && PENABLE && !r_pready && w_hit) begin
                    w_acc    = 1'b1;
                    w_nstate = w_rd_rx ? ST_RD_WAIT : ST_RESP;
                end
            end
            ST_RD_WAIT: begin
                if (r_cnt == 2'd1) begin
                    w_cap    = 1'b1;
                    w_nstate = ST_RESP;
                end
            end
            ST_RESP: w_nstate = ST_IDLE;
            default: w_nstate = ST_IDLE;
        endcase
    end

    assign w_wr_ok    = w_acc & PWRITE & ~w_err;
    assign w_ctrl_wr  = w_wr_ok & w_reg & (w_off == OFF_CTRL);
    assign w_intst_wr = w_wr_ok & w_reg & (w_off == OFF_INTST);
    assign w_rx_data  = (SWAP_RD != 0) ? bswap32(RXM_RD) : RXM_RD;

    // Events: a done edge beats a same-cycle CPU start; hardware sets beat W1C.
    genvar g;
    for (g = 0; g < N_TX; g++) begin : g_tx_sync
        ttc_edge_sync u_sync (
            .i_clk(Clk), .i_rst(Rst),
            .i_async(Tx_Finish[g]), .o_rise(w_tx_rise[g])
        );
    end
    for (g = 0; g < N_RX; g++) begin : g_rx_sync
        ttc_edge_sync u_sync (
            .i_clk(Clk), .i_rst(Rst),
            .i_async(Rx_Finish[g]), .o_rise(w_rx_rise[g])
        );
    end

    assign w_tx_set  = w_ctrl_wr ? PWDATA[TX_BIT +: N_TX] : '0;
    assign w_rx_clr  = w_ctrl_wr ? PWDATA[RX_BIT +: N_RX] : '0;
    assign w_tx_done = w_tx_rise & (r_tx_start | w_tx_set);
    assign w_int_clr = w_intst_wr ? PWDATA : '0;

    always_comb begin
        w_int_set = '0;
        w_int_set[TX_BIT +: N_TX] = w_tx_done;
        w_int_set[RX_BIT +: N_RX] = w_rx_rise;
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_tx_start <= '0;
            r_rx_ready <= '0;
            r_int_stat <= '0;
            r_int_en   <= '0;
            r_mask     <= '0;
            r_addr     <= '0;
            r_irq      <= 1'b0;
        end else begin
            r_tx_start <= (r_tx_start | w_tx_set) & ~w_tx_done;
            r_rx_ready <= (r_rx_ready & ~w_rx_clr) | w_rx_rise;
            r_int_stat <= ((r_int_stat & ~w_int_clr) | w_int_set) & INT_MASK;
            r_irq      <= |(r_int_stat & r_int_en);
            if (w_wr_ok && w_reg && w_off == OFF_INTEN) r_int_en <= PWDATA & INT_MASK;
            if (w_wr_ok && w_reg && w_off == OFF_MASK)  r_mask <= PWDATA[15:0];
            if (w_wr_ok && w_reg && w_off == OFF_ADDR)  r_addr <= PWDATA[15:0];
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_cnt     <= '0;
            r_txm_wen <= 1'b0;
            r_txm_wa  <= '0;
            r_txm_wd  <= '0;
            r_rxm_ren <= 1'b0;
            r_rxm_ra  <= '0;
        end else begin
            r_pready  <= (w_acc & ~w_rd_rx) | w_cap;
            r_pslverr <= w_acc & w_err;
            r_txm_wen <= w_wr_ok & w_tx;
            r_rxm_ren <= w_acc & w_rd_rx;
            if (w_acc) begin
                r_prdata <= w_err ? ERR_RDATA :
                            (w_reg && !PWRITE) ? w_reg_rd : '0;
            end else if (w_cap) begin
                r_prdata <= w_rx_data;
            end
            if (w_acc)                      r_cnt <= 2'(RD_LAT);
            else if (r_state == ST_RD_WAIT) r_cnt <= r_cnt - 2'd1;
            if (w_wr_ok && w_tx) begin
                r_txm_wa <= TXA_W'((w_txc << BUF_AW) | w_word);
                r_txm_wd <= PWDATA;
            end
            if (w_acc && w_rd_rx) r_rxm_ra <= RXA_W'((w_rxc << BUF_AW) | w_word);
        end
    end

    assign PRDATA   = r_prdata;
    assign PREADY   = r_pready;
    assign PSLVERR  = r_pslverr;
    assign Tx_Start = r_tx_start;
    assign Rx_Ready = r_rx_ready;
    assign Irq      = r_irq;
    assign MASK     = r_mask;
    assign ADDR     = r_addr;
    assign TXM_WEN  = r_txm_wen;
    assign TXM_WA   = r_txm_wa;
    assign TXM_WD   = r_txm_wd;
    assign RXM_REN  = r_rxm_ren;
    assign RXM_RA   = r_rxm_ra;

endmodule

// File: tb/tb_ttc_apb_bridge_mc.sv
// Directed bench for ttc_apb_bridge_mc (N_TX=2, N_RX=2, BUF_AW=8,
// RD_LAT=2, SWAP_RD=1).
module tb_ttc_apb_bridge_mc;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;
    logic [15:0] SpacecraftID;
    logic [31:0] TM_Packet_Counter, TC_Packet_Counter, TC_Error_Counter;
    logic        Flag_Sending, Flag_RX_ing;
    logic [1:0]  Tx_Finish, Rx_Finish, Tx_Start, Rx_Ready;
    logic        Irq;
    logic [15:0] MASK, ADDR;
    logic        TXM_WEN, RXM_REN;
    logic [8:0]  TXM_WA, RXM_RA;
    logic [31:0] TXM_WD, RXM_RD;

    int n_chk = 0;
    int n_err = 0;
    int wen_cnt = 0;
    int ren_cnt = 0;

    ttc_apb_bridge_mc #(
        .N_TX(2), .N_RX(2), .BUF_AW(8), .RD_LAT(2), .SWAP_RD(1),
        .BASE_ADDR(32'h3000_0000), .TM_LEN(1784), .TC_LEN(1792)
    ) dut (
        .Clk(Clk), .Rst(Rst), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .SpacecraftID(SpacecraftID),
        .TM_Packet_Counter(TM_Packet_Counter),
        .TC_Packet_Counter(TC_Packet_Counter),
        .TC_Error_Counter(TC_Error_Counter),
        .Flag_Sending(Flag_Sending), .Flag_RX_ing(Flag_RX_ing),
        .Tx_Finish(Tx_Finish), .Rx_Finish(Rx_Finish),
        .Tx_Start(Tx_Start), .Rx_Ready(Rx_Ready), .Irq(Irq),
        .MASK(MASK), .ADDR(ADDR),
        .TXM_WEN(TXM_WEN), .TXM_WA(TXM_WA), .TXM_WD(TXM_WD),
        .RXM_REN(RXM_REN), .RXM_RA(RXM_RA), .RXM_RD(RXM_RD)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (TXM_WEN === 1'b1) wen_cnt++;
    always @(negedge Clk) if (RXM_REN === 1'b1) ren_cnt++;

    // One APB transfer; n = access cycle in which PREADY was seen.
    task automatic apb(input logic [31:0] a, input logic [31:0] wd,
                       input logic wr, output logic [31:0] rd,
                       output logic er, output int n);
        @(negedge Clk);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWDATA = wd; PWRITE = wr;
        @(negedge Clk);
        PENABLE = 1'b1;
        n = 1;
        for (int k = 0; k < 16; k++) begin
            @(negedge Clk);
            n++;
            if (PREADY === 1'b1) break;
        end
        if (PREADY !== 1'b1) begin
            n_chk++; n_err++;
            $display("FAIL apb_timeout: addr %h got PREADY %b want 1", a, PREADY);
        end
        rd = PRDATA;
        er = PSLVERR;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_reset;
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        n_chk++; if ({PREADY, PSLVERR, Irq, TXM_WEN, RXM_REN} !== 5'b0) begin
            n_err++; $display("FAIL rst_ctl: got %b want 0", {PREADY, PSLVERR, Irq, TXM_WEN, RXM_REN}); end
        n_chk++; if (PRDATA !== 32'h0) begin
            n_err++; $display("FAIL rst_prdata: got %h want 0", PRDATA); end
        n_chk++; if ({Tx_Start, Rx_Ready} !== 4'b0) begin
            n_err++; $display("FAIL rst_status: got %b want 0", {Tx_Start, Rx_Ready}); end
        n_chk++; if ({MASK, ADDR} !== 32'h0) begin
            n_err++; $display("FAIL rst_filter: got %h want 0", {MASK, ADDR}); end
        n_chk++; if ({TXM_WA, RXM_RA, TXM_WD} !== 50'h0) begin
            n_err++; $display("FAIL rst_ram: got %h want 0", {TXM_WA, RXM_RA, TXM_WD}); end
        Rst = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_regs;
        logic [31:0] rd; logic er; int n;
        apb(32'h3000_0004, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0000_1A2B) begin
            n_err++; $display("FAIL scid_rdata: got %h want 00001a2b", rd); end
        n_chk++; if (n !== 2 || er !== 1'b0) begin
            n_err++; $display("FAIL scid_resp: got cyc %0d err %b want 2 0", n, er); end
        apb(32'h3000_0008, 32'hFFFF_BEEF, 1'b1, rd, er, n);
        n_chk++; if (MASK !== 16'hBEEF) begin
            n_err++; $display("FAIL mask_out: got %h want beef", MASK); end
        apb(32'h3000_0008, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0000_BEEF) begin
            n_err++; $display("FAIL mask_rd: got %h want 0000beef", rd); end
        apb(32'h3000_000C, 32'h1234_5678, 1'b1, rd, er, n);
        n_chk++; if (ADDR !== 16'h5678) begin
            n_err++; $display("FAIL addr_out: got %h want 5678", ADDR); end
        apb(32'h3000_0000, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h8000_0000) begin
            n_err++; $display("FAIL status_idle: got %h want 80000000", rd); end
        apb(32'h3000_0018, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0000_06F8) begin
            n_err++; $display("FAIL tm_len: got %h want 000006f8", rd); end
        apb(32'h3000_0030, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'hCAFE_0001) begin
            n_err++; $display("FAIL tm_cnt: got %h want cafe0001", rd); end
        apb(32'h3000_0038, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0000_0007) begin
            n_err++; $display("FAIL tc_err_cnt: got %h want 00000007", rd); end
    endtask

    task automatic test_tx_write;
        logic [31:0] rd; logic er; int n; int w0;
        w0 = wen_cnt;
        apb(32'h3000_2004, 32'hDEAD_BEEF, 1'b1, rd, er, n);
        n_chk++; if (wen_cnt - w0 !== 1 || er !== 1'b0 || n !== 2) begin
            n_err++; $display("FAIL tx_wr_pulse: got wen %0d err %b cyc %0d want 1 0 2", wen_cnt - w0, er, n); end
        n_chk++; if (TXM_WA !== 9'h001 || TXM_WD !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL tx_wr_addr: got %h/%h want 001/deadbeef", TXM_WA, TXM_WD); end
        apb(32'h3000_0000, 32'h0000_0001, 1'b1, rd, er, n);
        n_chk++; if (Tx_Start !== 2'b01) begin
            n_err++; $display("FAIL tx_start_set: got %b want 01", Tx_Start); end
        apb(32'h3000_0000, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h8000_0001) begin
            n_err++; $display("FAIL status_tx: got %h want 80000001", rd); end
        w0 = wen_cnt;
        apb(32'h3000_2004, 32'h5555_AAAA, 1'b1, rd, er, n);
        n_chk++; if (er !== 1'b1 || wen_cnt - w0 !== 0) begin
            n_err++; $display("FAIL tx_locked: got err %b wen %0d want 1 0", er, wen_cnt - w0); end
        apb(32'h3000_4008, 32'h0BAD_F00D, 1'b1, rd, er, n);
        n_chk++; if (TXM_WA !== 9'h102 || TXM_WD !== 32'h0BAD_F00D || er !== 1'b0) begin
            n_err++; $display("FAIL tx_ch1_wr: got %h/%h err %b want 102/0badf00d 0", TXM_WA, TXM_WD, er); end
    endtask

    task automatic test_tx_done;
        logic [31:0] rd; logic er; int n; int k;
        apb(32'h3000_0010, 32'h0000_0001, 1'b1, rd, er, n);
        Tx_Finish[0] = 1'b1;
        for (k = 1; k <= 5; k++) begin
            @(negedge Clk);
            if (Tx_Start[0] === 1'b0) break;
        end
        n_chk++; if (k > 3) begin
            n_err++; $display("FAIL tx_done_lat: got %0d cycles want <=3", k); end
        n_chk++; if (Irq !== 1'b0) begin
            n_err++; $display("FAIL irq_early: got %b want 0", Irq); end
        @(negedge Clk);
        n_chk++; if (Irq !== 1'b1) begin
            n_err++; $display("FAIL irq_set: got %b want 1", Irq); end
        apb(32'h3000_0014, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0000_0001) begin
            n_err++; $display("FAIL int_stat_tx: got %h want 00000001", rd); end
        apb(32'h3000_0014, 32'h0000_0001, 1'b1, rd, er, n);
        n_chk++; if (Irq !== 1'b0) begin
            n_err++; $display("FAIL irq_clear: got %b want 0", Irq); end
        apb(32'h3000_0014, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0) begin
            n_err++; $display("FAIL int_stat_w1c: got %h want 0", rd); end
        Tx_Finish[0] = 1'b0;
    endtask

    task automatic test_rx_read;
        logic [31:0] rd; logic er; int n; int r0;
        r0 = ren_cnt;
        apb(32'h3000_800C, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h4433_2211) begin
            n_err++; $display("FAIL rx_rdata: got %h want 44332211", rd); end
        n_chk++; if (n !== 4 || er !== 1'b0) begin
            n_err++; $display("FAIL rx_resp: got cyc %0d err %b want 4 0", n, er); end
        n_chk++; if (RXM_RA !== 9'h103 || ren_cnt - r0 !== 1) begin
            n_err++; $display("FAIL rx_addr: got %h ren %0d want 103 1", RXM_RA, ren_cnt - r0); end
    endtask

    task automatic test_rx_collision;
        logic [31:0] rd; logic er; int n;
        Rx_Finish[1] = 1'b1;
        repeat (4) @(negedge Clk);
        n_chk++; if (Rx_Ready !== 2'b10) begin
            n_err++; $display("FAIL rx_ready_set: got %b want 10", Rx_Ready); end
        Rx_Finish[1] = 1'b0;
        repeat (3) @(negedge Clk);
        apb(32'h3000_0014, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0002_0000) begin
            n_err++; $display("FAIL int_stat_rx: got %h want 00020000", rd); end
        apb(32'h3000_0014, 32'h0002_0000, 1'b1, rd, er, n);
        apb(32'h3000_0014, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0) begin
            n_err++; $display("FAIL int_stat_rx_w1c: got %h want 0", rd); end
        // Rise lands on the same edge as the W1C access cycle.
        Rx_Finish[1] = 1'b1;
        apb(32'h3000_0014, 32'h0002_0000, 1'b1, rd, er, n);
        apb(32'h3000_0014, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h0002_0000) begin
            n_err++; $display("FAIL int_set_wins: got %h want 00020000", rd); end
        Rx_Finish[1] = 1'b0;
        repeat (3) @(negedge Clk);
        apb(32'h3000_0000, 32'h0002_0000, 1'b1, rd, er, n);
        n_chk++; if (Rx_Ready !== 2'b00) begin
            n_err++; $display("FAIL rx_ready_w1c: got %b want 00", Rx_Ready); end
        Rx_Finish[1] = 1'b1;
        apb(32'h3000_0000, 32'h0002_0000, 1'b1, rd, er, n);
        n_chk++; if (Rx_Ready !== 2'b10) begin
            n_err++; $display("FAIL ready_set_wins: got %b want 10", Rx_Ready); end
        Rx_Finish[1] = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic er; int n; int c0;
        apb(32'h3000_0020, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (er !== 1'b1 || rd !== 32'hFFFF_FFFF || n !== 2) begin
            n_err++; $display("FAIL err_unmapped: got err %b rd %h cyc %0d want 1 ffffffff 2", er, rd, n); end
        c0 = ren_cnt;
        apb(32'h3000_6400, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (er !== 1'b1 || rd !== 32'hFFFF_FFFF || ren_cnt - c0 !== 0) begin
            n_err++; $display("FAIL err_rx_idx: got err %b rd %h ren %0d want 1 ffffffff 0", er, rd, ren_cnt - c0); end
        apb(32'h3000_0004, 32'h0000_FFFF, 1'b1, rd, er, n);
        n_chk++; if (er !== 1'b1) begin
            n_err++; $display("FAIL err_ro_write: got err %b want 1", er); end
        c0 = wen_cnt;
        apb(32'h3000_4400, 32'h1, 1'b1, rd, er, n);
        n_chk++; if (er !== 1'b1 || wen_cnt - c0 !== 0) begin
            n_err++; $display("FAIL err_tx_idx: got err %b wen %0d want 1 0", er, wen_cnt - c0); end
    endtask

    task automatic test_reset_rdwait;
        logic [31:0] rd; logic er; int n;
        @(negedge Clk);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h3000_800C; PWRITE = 1'b0;
        @(negedge Clk);
        PENABLE = 1'b1;
        @(negedge Clk);
        n_chk++; if (RXM_REN !== 1'b1) begin
            n_err++; $display("FAIL rdwait_ren: got %b want 1", RXM_REN); end
        Rst = 1'b1;
        #1;
        n_chk++; if ({PREADY, PSLVERR, RXM_REN, RXM_RA, Rx_Ready, MASK} !== 30'h0) begin
            n_err++; $display("FAIL rdwait_rst_out: got %h want 0", {PREADY, PSLVERR, RXM_REN, RXM_RA, Rx_Ready, MASK}); end
        n_chk++; if (PRDATA !== 32'h0) begin
            n_err++; $display("FAIL rdwait_rst_prdata: got %h want 0", PRDATA); end
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (2) @(negedge Clk);
        n_chk++; if (PREADY !== 1'b0) begin
            n_err++; $display("FAIL rdwait_no_ready: got %b want 0", PREADY); end
        Rst = 1'b0;
        @(negedge Clk);
        apb(32'h3000_800C, 32'h0, 1'b0, rd, er, n);
        n_chk++; if (rd !== 32'h4433_2211 || n !== 4 || er !== 1'b0) begin
            n_err++; $display("FAIL post_rst_read: got %h cyc %0d err %b want 44332211 4 0", rd, n, er); end
    endtask

    initial begin
        Rst = 1'b1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0;
        SpacecraftID = 16'h1A2B;
        TM_Packet_Counter = 32'hCAFE_0001;
        TC_Packet_Counter = 32'h0000_0102;
        TC_Error_Counter = 32'h0000_0007;
        Flag_Sending = 1'b1;
        Flag_RX_ing = 1'b0;
        Tx_Finish = '0;
        Rx_Finish = '0;
        RXM_RD = 32'h1122_3344;
        test_reset;
        test_regs;
        test_tx_write;
        test_tx_done;
        test_rx_read;
        test_rx_collision;
        test_errors;
        test_reset_rdwait;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/ttc_apb_bridge_mc.md
Name: ttc_apb_bridge_mc

Overview:
- Parametrised APB3 slave bridging the SmartFusion2 MSS to the TTC telemetry (TX) and telecommand (RX) packet buffers.
- Generalises the fixed two-channel A/B glue to N_TX/N_RX channels:
  - word-wide buffer writes instead of byte-serialised writes;
  - configurable RX read latency and byte swap;
  - maskable write-1-to-clear (W1C) interrupts;
  - PSLVERR on bad accesses.
- Sits between the APB fabric interface and the TX/RX dual-port buffer RAMs and framing cores.

Parameters:
- N_TX, 2: TX channels (1..8).
- N_RX, 2: RX channels (1..8).
- BUF_AW, 8: word-address width per channel window (≤11; window = 4<<BUF_AW bytes).
- RD_LAT, 1: RX RAM read latency in cycles (1..3).
- SWAP_RD, 1: 1 = byte-reverse RX read data before PRDATA.
- BASE_ADDR, 32'h30000000: block base; must be 256 KB aligned.
- TM_LEN, 1784: TM frame length in bits, read-only register.
- TC_LEN, 1792: TC frame length in bits, read-only register.

Ports:
- Clk  in  1  system clock
- Rst  in  1  asynchronous reset, active-high
- PSEL, PENABLE, PWRITE  in  1  APB control
- PADDR  in  32  APB address
- PWDATA  in  32  APB write data
- PRDATA  out  32  APB read data, registered
- PREADY  out  1  APB ready, registered single-cycle pulse
- PSLVERR  out  1  APB error, valid with PREADY
- SpacecraftID  in  16  spacecraft ID, read-only register
- TM_Packet_Counter, TC_Packet_Counter, TC_Error_Counter  in  32  status counters
- Flag_Sending, Flag_RX_ing  in  1  framing status, read directly
- Tx_Finish  in  N_TX  per-channel TX-done level from framing, asynchronous domain
- Rx_Finish  in  N_RX  per-channel RX-done level, asynchronous domain
- Tx_Start  out  N_TX  per-channel send request level
- Rx_Ready  out  N_RX  per-channel packet-available level
- Irq  out  1  registered interrupt request
- MASK, ADDR  out  16  filter registers
- TXM_WEN  out  1  TX RAM write enable, 1 cycle
- TXM_WA  out  $clog2(N_TX)+BUF_AW  address = {channel, word}
- TXM_WD  out  32  TX RAM write data
- RXM_REN  out  1  RX RAM read enable, 1 cycle
- RXM_RA  out  $clog2(N_RX)+BUF_AW  address = {channel, word}
- RXM_RD  in  32  RX RAM read data, valid RD_LAT cycles after RXM_REN

Behaviour:

Reset:
- Every output and register is 0.
- FSM enters IDLE.
- A reset during a transfer abandons it; PREADY stays 0.

Address decode:
- Hit when PADDR[31:18]==BASE_ADDR[31:18].
- Region r=PADDR[17:13]:
  - r=0: registers.
  - r=1..N_TX: TX channel r-1.
  - r=N_TX+1..N_TX+N_RX: RX channel r-N_TX-1.
- Word index = PADDR[12:2]. Index ≥ 2^BUF_AW → error. PADDR[1:0] is ignored.
- Registers, by byte offset:
  - 00 CTRL/STATUS (read/write)
  - 04 SCID (read-only)
  - 08 MASK (read/write)
  - 0C ADDR (read/write)
  - 10 INT_EN (read/write)
  - 14 INT_STAT (W1C)
  - 18 TM_LEN (read-only)
  - 1C TC_LEN (read-only)
  - 30/34/38 TM/TC/TC-error counters (read-only)
  - Any other offset → error.
- STATUS read value: [N_TX-1:0]=Tx_Start, [16+N_RX-1:16]=Rx_Ready, [30]=Flag_RX_ing, [31]=Flag_Sending, all other bits 0.

APB FSM, states IDLE, RD_WAIT, RESP:
- IDLE, on first access cycle (PSEL&PENABLE&!PREADY), A1:
  - Register access, TX write, or error: PREADY=1 in A2 → two access cycles.
  - TX write: TXM_WEN=1, TXM_WA, TXM_WD=PWDATA in A2.
  - RX read: RXM_REN=1 with RXM_RA in A2 → RD_WAIT; counter loads RD_LAT.
- RD_WAIT: capture RXM_RD (swapped if SWAP_RD) into PRDATA when the count expires; PREADY in the following cycle → 2+RD_LAT access cycles.
- RESP: PREADY high one cycle, then back to IDLE. No new transfer is decoded while PREADY=1.
- Errors:
  - Covers unmapped offsets, out-of-range word index, writes to read-only registers, and TX-window writes while Tx_Start[c]=1 (buffer locked).
  - Response: PSLVERR=1 and no side effect; a failed read returns PRDATA=FFFF_FFFF.
- Non-hit address: no response is driven (PREADY stays 0, left to the fabric decoder).

Control (CTRL writes):
- Bit c written 1 sets Tx_Start[c]; writing 0 has no effect.
- Bit 16+c written 1 clears Rx_Ready[c] (W1C).

Events:
- Each Tx_Finish/Rx_Finish bit goes through a 2-flop synchroniser plus rising-edge detect, giving a 3-cycle maximum latency.
- TX edge on channel c while Tx_Start[c]=1:
  - clears Tx_Start[c];
  - sets INT_STAT[c].
- A TX edge while Tx_Start[c]=0 is ignored (spurious).
- RX edge: sets Rx_Ready[c] and INT_STAT[16+c].
- Simultaneous events:
  - CPU start and done edge in the same cycle: the done edge wins (Tx_Start cleared).
  - Hardware set and W1C in the same cycle: the set wins, for both INT_STAT and Rx_Ready.

Interrupt:
- Irq <= |(INT_STAT & INT_EN), registered, so it asserts one cycle after INT_STAT sets.

Decomposition:
- Package ttc_apb_pkg holds:
  - register offset constants;
  - CTRL/INT bit positions (TX at bit 0, RX at bit 16);
  - FSM state enum;
  - ERR_RDATA constant = FFFF_FFFF.
- Sub-module ttc_edge_sync: 2-flop synchroniser plus rising-edge pulse, instantiated N_TX+N_RX times.

Test Plan:
1. Reset, then read 0x30000004 with SpacecraftID=16'h1A2B → PRDATA=0000_1A2B, PREADY in A2, PSLVERR=0.
2. Write 0x30002004 with DEADBEEF (TX ch0, word 1) → one TXM_WEN pulse, TXM_WA=1, TXM_WD=DEADBEEF. Then write 0x30000000 with 1 → Tx_Start[0]=1. Repeat the TX write → PSLVERR=1 and no TXM_WEN.
3. Raise Tx_Finish[0] → within 3 cycles Tx_Start[0]=0 and INT_STAT[0]=1. With INT_EN=1, Irq=1 the next cycle. Write 0x30000014 with 1 → Irq=0.
4. RD_LAT=2, SWAP_RD=1, RXM_RD=11223344 at the RX ch1 window (0x3000_8000 for N_TX=2), word 3 → RXM_RA={1,3}, PRDATA=44332211, PREADY in access cycle 4.
5. Rx_Finish[1] edge in the same cycle as a W1C write to INT_STAT bit 17 → INT_STAT[17] stays 1 and Rx_Ready[1]=1.
6. Read offset 0x20, and read RX word index 2^BUF_AW → PSLVERR=1, PRDATA=FFFF_FFFF. Assert Rst during RD_WAIT → all outputs 0 and the next transfer completes normally.
